// File: rtl/mdio_pkg.sv
// Shared constants, frame layout and FSM encoding for the MDIO management arbiter.
package mdio_pkg;

    localparam int unsigned FRAME_W = 32;
    localparam int unsigned PHY_W   = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned DATA_W  = 16;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;
    localparam logic [1:0] TA_READ  = 2'b00;

    localparam int unsigned ST_LSB   = 30;
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned PHY_LSB  = 23;
    localparam int unsigned REG_LSB  = 18;
    localparam int unsigned TA_LSB   = 16;
    localparam int unsigned DATA_LSB = 0;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [1:0]        st;
        logic [1:0]        op;
        logic [PHY_W-1:0]  phy;
        logic [REG_W-1:0]  regad;
        logic [1:0]        ta;
        logic [DATA_W-1:0] data;
    } mdio_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic mdio_frame_t build_frame(
        input logic              rw,
        input logic [PHY_W-1:0]  phy,
        input logic [REG_W-1:0]  regad,
        input logic [DATA_W-1:0] wdata
    );
        mdio_frame_t f;
        f.st    = ST_CODE;
        f.op    = rw ? OP_WRITE : OP_READ;
        f.phy   = phy;
        f.regad = regad;
        f.ta    = rw ? TA_WRITE : TA_READ;
        f.data  = rw ? wdata : DATA_W'(0);
        return f;
    endfunction

endpackage

// File: rtl/mdio_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module mdio_rr_arbiter (
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       last_b_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    assign gnt_o[0] = req_a_i & (~req_b_i | last_b_i);
    assign gnt_o[1] = req_b_i & (~req_a_i | ~last_b_i);
    assign valid_o  = req_a_i | req_b_i;

endmodule

// File: rtl/mdio_arbiter.sv
// Two-host Clause-22 MDIO arbiter: grants round-robin, builds the frame,
// strobes the generator and returns ACK/ERR/RDATA with a completion timeout.
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int unsigned TIMEOUT = 80
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a_i,
    input  logic               req_b_i,
    input  logic               rw_a_i,
    input  logic               rw_b_i,
    input  logic [PHY_W-1:0]   phy_a_i,
    input  logic [PHY_W-1:0]   phy_b_i,
    input  logic [REG_W-1:0]   reg_a_i,
    input  logic [REG_W-1:0]   reg_b_i,
    input  logic [DATA_W-1:0]  wdata_a_i,
    input  logic [DATA_W-1:0]  wdata_b_i,
    output logic               ack_a_o,
    output logic               ack_b_o,
    output logic               err_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               busy_o,
    output logic [FRAME_W-1:0] t_data_o,
    output logic               mdio_start_o,
    input  logic               mdio_done_i,
    input  logic [DATA_W-1:0]  rd_data_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_b_q, last_b_d;
    logic              win_b_q, win_b_d;
    logic              rw_q, rw_d;
    mdio_frame_t       t_data_q, t_data_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        gnt;
    logic              gnt_valid;
    logic              sel_rw;
    logic [PHY_W-1:0]  sel_phy;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_wdata;

    mdio_rr_arbiter u_rr (
        .req_a_i  (req_a_i),
        .req_b_i  (req_b_i),
        .last_b_i (last_b_q),
        .gnt_o    (gnt),
        .valid_o  (gnt_valid)
    );

    // Winner's request fields; only consumed on the grant edge.
    assign sel_rw    = gnt[1] ? rw_b_i    : rw_a_i;
    assign sel_phy   = gnt[1] ? phy_b_i   : phy_a_i;
    assign sel_reg   = gnt[1] ? reg_b_i   : reg_a_i;
    assign sel_wdata = gnt[1] ? wdata_b_i : wdata_a_i;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        win_b_d  = win_b_q;
        rw_d     = rw_q;
        t_data_d = t_data_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    win_b_d  = gnt[1];
                    rw_d     = sel_rw;
                    t_data_d = build_frame(sel_rw, sel_phy, sel_reg, sel_wdata);
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Completion takes priority over a coincident timeout.
                if (mdio_done_i) begin
                    if (!rw_q) begin
                        rdata_d = rd_data_i;
                    end
                    ack_a_d = ~win_b_q;
                    ack_b_d = win_b_q;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    ack_a_d = ~win_b_q;
                    ack_b_d = win_b_q;
                    err_d   = 1'b1;
                    rdata_d = 16'hFFFF;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                busy_d   = 1'b0;
                last_b_d = win_b_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            win_b_q  <= 1'b0;
            rw_q     <= 1'b0;
            t_data_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            win_b_q  <= win_b_d;
            rw_q     <= rw_d;
            t_data_q <= t_data_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ack_a_o      = ack_a_q;
    assign ack_b_o      = ack_b_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign busy_o       = busy_q;
    assign t_data_o     = t_data_q;
    assign mdio_start_o = start_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed scoreboard bench for mdio_arbiter: frames, arbitration order,
// completion/timeout responses and mid-transaction reset.
module tb_mdio_arbiter;

    localparam int TO = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        rw_a = 1'b0, rw_b = 1'b0;
    logic [4:0]  phy_a = '0, phy_b = '0;
    logic [4:0]  reg_a = '0, reg_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        mdio_done = 1'b0;
    logic [15:0] rd_data = '0;
    logic        ack_a, ack_b, err, busy, mdio_start;
    logic [15:0] rdata;
    logic [31:0] t_data;

    typedef struct {
        logic [31:0] frame;
        logic        ack_b;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mdio_arbiter #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rw_a_i       (rw_a),
        .rw_b_i       (rw_b),
        .phy_a_i      (phy_a),
        .phy_b_i      (phy_b),
        .reg_a_i      (reg_a),
        .reg_b_i      (reg_b),
        .wdata_a_i    (wdata_a),
        .wdata_b_i    (wdata_b),
        .ack_a_o      (ack_a),
        .ack_b_o      (ack_b),
        .err_o        (err),
        .rdata_o      (rdata),
        .busy_o       (busy),
        .t_data_o     (t_data),
        .mdio_start_o (mdio_start),
        .mdio_done_i  (mdio_done),
        .rd_data_i    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] frame, input logic is_b, input logic e_err,
                        input logic [15:0] e_rdata);
        exp_t e;
        e.frame = frame;
        e.ack_b = is_b;
        e.err   = e_err;
        e.rdata = e_rdata;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_t_data"}, t_data, 32'h0);
        chk({tag, "_start"}, 32'(mdio_start), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_ack"}, 32'({ack_b, ack_a}), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    endtask

    // Waits for the start strobe, checks the frame, supplies DONE after dly
    // WAIT edges (dly < 0: never) and checks the response against the scoreboard.
    task automatic serve(input int dly, input logic [15:0] rd);
        exp_t e;
        int   c;
        bit   found;
        bit   got;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            found = mdio_start;
        end
        chk("start_seen", 32'(found), 32'h1);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
        if (!found || sb.size() == 0) return;
        e = sb.pop_front();
        chk("t_data", t_data, e.frame);
        chk("busy_at_start", 32'(busy), 32'h1);
        c   = 0;
        got = 1'b0;
        while (c < TO + 10 && !got) begin
            if (c == dly) begin
                mdio_done = 1'b1;
                rd_data   = rd;
            end
            @(posedge clk); #1;
            mdio_done = 1'b0;
            c++;
            if (c == 1) chk("start_one_cycle", 32'(mdio_start), 32'h0);
            got = ack_a | ack_b;
        end
        chk("ack_latency", 32'(c), 32'(dly >= 0 ? dly + 1 : TO));
        chk("ack_a", 32'(ack_a), 32'(!e.ack_b));
        chk("ack_b", 32'(ack_b), 32'(e.ack_b));
        chk("err", 32'(err), 32'(e.err));
        chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("busy_at_ack", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("ack_cleared", 32'({ack_b, ack_a}), 32'h0);
        chk("err_cleared", 32'(err), 32'h0);
        chk("busy_fell", 32'(busy), 32'h0);
        chk("rdata_held", 32'(rdata), 32'(e.rdata));
        chk("t_data_stable", t_data, e.frame);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Write from A; DONE 40 cycles after start, rdata untouched.
        rw_a = 1'b1; phy_a = 5'h03; reg_a = 5'h1A; wdata_a = 16'hBEEF;
        push(32'h51EABEEF, 1'b0, 1'b0, 16'h0000);
        req_a = 1'b1;
        serve(39, 16'hCAFE);
        req_a = 1'b0;

        // Read from B, quickest completion.
        rw_b = 1'b0; phy_b = 5'h1F; reg_b = 5'h02;
        push(32'h6F880000, 1'b1, 1'b0, 16'h1234);
        req_b = 1'b1;
        serve(0, 16'h1234);
        req_b = 1'b0;

        // Both held across three transactions: A, B, A.
        rw_a = 1'b0; phy_a = 5'h01; reg_a = 5'h05;
        rw_b = 1'b0; phy_b = 5'h02; reg_b = 5'h06;
        push(32'h60940000, 1'b0, 1'b0, 16'hA001);
        push(32'h61180000, 1'b1, 1'b0, 16'hB002);
        push(32'h60940000, 1'b0, 1'b0, 16'hA003);
        req_a = 1'b1; req_b = 1'b1;
        serve(0, 16'hA001);
        serve(0, 16'hB002);
        serve(0, 16'hA003);
        req_a = 1'b0; req_b = 1'b0;

        // Timeout with no DONE.
        rw_a = 1'b0; phy_a = 5'h04; reg_a = 5'h07;
        push(32'h621C0000, 1'b0, 1'b1, 16'hFFFF);
        req_a = 1'b1;
        serve(-1, 16'h0000);
        req_a = 1'b0;

        // DONE on the timeout edge: completion wins.
        rw_b = 1'b0; phy_b = 5'h05; reg_b = 5'h08;
        push(32'h62A00000, 1'b1, 1'b0, 16'h5A5A);
        req_b = 1'b1;
        serve(TO - 1, 16'h5A5A);
        req_b = 1'b0;

        // Reset mid-WAIT drops the transaction.
        rw_a = 1'b1; phy_a = 5'h06; reg_a = 5'h09; wdata_a = 16'h1111;
        req_a = 1'b1;
        @(posedge clk); #1;
        chk("rst_txn_start", 32'(mdio_start), 32'h1);
        chk("rst_txn_t_data", t_data, 32'h53261111);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_a = 1'b0;
        #2;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdio_done = 1'b1;
        rd_data   = 16'hDEAD;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mdio_done = 1'b0;
            if (ack_a || ack_b || mdio_start || busy) seen++;
        end
        chk("no_activity_after_reset", 32'(seen), 32'h0);
        chk("rdata_after_reset", 32'(rdata), 32'h0);

        rw_b = 1'b0; phy_b = 5'h07; reg_b = 5'h0A;
        push(32'h63A80000, 1'b1, 1'b0, 16'h7777);
        req_b = 1'b1;
        serve(3, 16'h7777);
        req_b = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
